// File: rtl/udp_axis_master.sv
// ---------------------------------------------------------------------------
// udp_axis_master
//
// Receive side of the UDP AXI-Stream link. Takes UDP datagrams from the UDP RX
// stack as a header handshake followed by an 8-bit payload stream. It filters
// on destination port and source IP, strips the leading 32-bit big-endian
// transfer ID, and repacks the remaining payload little-endian into a
// BYTE_COUNT-byte wide AXI-Stream for the application.
//
// Optional feature macro: UDP_AXIS_MASTER_SEQ_CHECK_EN
//   When defined, transfer IDs are checked for consecutive numbering. A
//   forwarded datagram whose ID is not last_id+1 gets app_tuser=1 on its final
//   beat. The first datagram after reset is never flagged.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   hdr_valid/hdr_ready     UDP RX header handshake
//   udp_dest_port           destination port of the offered datagram
//   ip_source_ip            IPv4 source address of the offered datagram
//   payload_t*              8-bit payload stream; tuser = bad frame
//   app_t*                  wide output stream (tdata/tkeep/tlast/tuser)
//   transfer_id             ID of the last accepted datagram
//   pkt_drop                one-cycle pulse per dropped datagram
// ---------------------------------------------------------------------------
module udp_axis_master #(
    parameter int          BYTE_COUNT = 4,
    parameter logic [15:0] UDP_PORT   = 16'd1234,
    parameter logic [31:0] SOURCE_IP  = {8'd192, 8'd168, 8'd1, 8'd1}
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      hdr_valid,
    output logic                      hdr_ready,
    input  logic [15:0]               udp_dest_port,
    input  logic [31:0]               ip_source_ip,

    input  logic [7:0]                payload_tdata,
    input  logic                      payload_tvalid,
    output logic                      payload_tready,
    input  logic                      payload_tlast,
    input  logic                      payload_tuser,

    output logic [8*BYTE_COUNT-1:0]   app_tdata,
    output logic [BYTE_COUNT-1:0]     app_tkeep,
    output logic                      app_tvalid,
    input  logic                      app_tready,
    output logic                      app_tlast,
    output logic                      app_tuser,

    output logic [31:0]               transfer_id,
    output logic                      pkt_drop
);

    localparam int CNT_W = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTE_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ID, DATA, DROP} state_t;

    state_t                  state;
    state_t                  state_nxt;

    // Holds hdr_ready low until the first clock after reset release.
    logic                    run;

    logic [1:0]              id_cnt;
    logic [23:0]             id_shadow;
    logic [31:0]             id_full;

    logic [CNT_W-1:0]        word_cnt;
    logic [8*BYTE_COUNT-1:0] word_buf;
    logic [8*BYTE_COUNT-1:0] word_nxt;
    logic [BYTE_COUNT-1:0]   keep_nxt;

    logic                    hdr_fire;
    logic                    in_fire;
    logic                    hdr_match;
    logic                    closes_word;
    logic                    out_free;
    logic                    seq_flag;

    assign hdr_fire    = hdr_valid & hdr_ready;
    assign in_fire     = payload_tvalid & payload_tready;
    assign hdr_match   = (udp_dest_port == UDP_PORT) &&
                         ((SOURCE_IP == 32'h0) || (ip_source_ip == SOURCE_IP));
    assign closes_word = payload_tlast || (word_cnt == LAST_IDX);
    assign out_free    = !app_tvalid || app_tready;
    assign id_full     = {id_shadow, payload_tdata};

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hdr_fire) state_nxt = hdr_match ? ID : DROP;
            end
            ID: begin
                // A tlast anywhere in the ID bytes (including the 4th) is a runt.
                if (in_fire) begin
                    if (payload_tlast)        state_nxt = IDLE;
                    else if (id_cnt == 2'd3)  state_nxt = DATA;
                end
            end
            DATA: begin
                if (in_fire && payload_tlast) state_nxt = IDLE;
            end
            DROP: begin
                if (in_fire && payload_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        hdr_ready      = 1'b0;
        payload_tready = 1'b0;
        case (state)
            IDLE: hdr_ready      = run;
            ID:   payload_tready = 1'b1;
            // Only a word-closing byte needs room in the output register.
            DATA: payload_tready = !closes_word || out_free;
            DROP: payload_tready = 1'b1;
            default: ;
        endcase
    end

    // Word under assembly with the incoming byte merged into its lane.
    always_comb begin
        word_nxt = word_buf;
        word_nxt[8*int'(word_cnt) +: 8] = payload_tdata;
        keep_nxt = '0;
        for (int k = 0; k < BYTE_COUNT; k++) begin
            keep_nxt[k] = (k <= int'(word_cnt));
        end
    end

`ifdef UDP_AXIS_MASTER_SEQ_CHECK_EN
    logic [31:0] exp_id;
    logic        have_id;
    logic        seq_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_id  <= 32'h0;
            have_id <= 1'b0;
            seq_err <= 1'b0;
        end else if (state == ID && in_fire && !payload_tlast && id_cnt == 2'd3) begin
            // Resync to whatever arrived so one gap flags only one datagram.
            seq_err <= have_id && (id_full != exp_id);
            exp_id  <= id_full + 32'd1;
            have_id <= 1'b1;
        end
    end

    assign seq_flag = seq_err;
`else
    assign seq_flag = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // ID capture, word packing and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run         <= 1'b0;
            id_cnt      <= 2'd0;
            id_shadow   <= 24'h0;
            transfer_id <= 32'h0;
            pkt_drop    <= 1'b0;
            word_cnt    <= '0;
            word_buf    <= '0;
            app_tdata   <= '0;
            app_tkeep   <= '0;
            app_tvalid  <= 1'b0;
            app_tlast   <= 1'b0;
            app_tuser   <= 1'b0;
        end else begin
            run      <= 1'b1;
            pkt_drop <= 1'b0;

            if (app_tvalid && app_tready) begin
                app_tvalid <= 1'b0;
            end

            if (hdr_fire) begin
                id_cnt   <= 2'd0;
                word_cnt <= '0;
                word_buf <= '0;
            end

            if (in_fire) begin
                case (state)
                    ID: begin
                        id_shadow <= id_full[23:0];
                        id_cnt    <= id_cnt + 2'd1;
                        if (payload_tlast) begin
                            pkt_drop <= 1'b1;
                        end else if (id_cnt == 2'd3) begin
                            transfer_id <= id_full;
                        end
                    end
                    DATA: begin
                        if (closes_word) begin
                            app_tdata  <= word_nxt;
                            app_tkeep  <= keep_nxt;
                            app_tvalid <= 1'b1;
                            app_tlast  <= payload_tlast;
                            app_tuser  <= payload_tlast & (payload_tuser | seq_flag);
                            word_buf   <= '0;
                            word_cnt   <= '0;
                        end else begin
                            word_buf <= word_nxt;
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                    DROP: begin
                        if (payload_tlast) pkt_drop <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_axis_master.sv
module tb_udp_axis_master;

    localparam int BC = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            hdr_valid = 1'b0;
    logic            hdr_ready;
    logic [15:0]     udp_dest_port = 16'h0;
    logic [31:0]     ip_source_ip = 32'h0;
    logic [7:0]      payload_tdata = 8'h0;
    logic            payload_tvalid = 1'b0;
    logic            payload_tready;
    logic            payload_tlast = 1'b0;
    logic            payload_tuser = 1'b0;
    logic [8*BC-1:0] app_tdata;
    logic [BC-1:0]   app_tkeep;
    logic            app_tvalid;
    logic            app_tready = 1'b1;
    logic            app_tlast;
    logic            app_tuser;
    logic [31:0]     transfer_id;
    logic            pkt_drop;

    udp_axis_master #(.BYTE_COUNT(BC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hdr_valid      (hdr_valid),
        .hdr_ready      (hdr_ready),
        .udp_dest_port  (udp_dest_port),
        .ip_source_ip   (ip_source_ip),
        .payload_tdata  (payload_tdata),
        .payload_tvalid (payload_tvalid),
        .payload_tready (payload_tready),
        .payload_tlast  (payload_tlast),
        .payload_tuser  (payload_tuser),
        .app_tdata      (app_tdata),
        .app_tkeep      (app_tkeep),
        .app_tvalid     (app_tvalid),
        .app_tready     (app_tready),
        .app_tlast      (app_tlast),
        .app_tuser      (app_tuser),
        .transfer_id    (transfer_id),
        .pkt_drop       (pkt_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef logic [7:0] byte_q_t[$];

    localparam logic [31:0] GOOD_IP = 32'hC0A8_0101;

`ifdef UDP_AXIS_MASTER_SEQ_CHECK_EN
    localparam logic SEQ_FLAG = 1'b1;
`else
    localparam logic SEQ_FLAG = 1'b0;
`endif

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    drop_cnt = 0;
    int    bp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        beat_t b;
        b.data = d; b.keep = k; b.last = l; b.user = u;
        exp_q.push_back(b);
    endtask

    function automatic byte_q_t make(input logic [31:0] id, input int n, input logic [7:0] start);
        byte_q_t q;
        q.push_back(id[31:24]); q.push_back(id[23:16]);
        q.push_back(id[15:8]);  q.push_back(id[7:0]);
        for (int i = 0; i < n; i++) q.push_back(start + 8'(i));
        return q;
    endfunction

    // Monitor / scoreboard: samples well after the falling edge, when all
    // stimulus and DUT outputs are stable ahead of the next rising edge.
    initial begin
        beat_t got;
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (app_tvalid && app_tready) begin
                got = {app_tdata, app_tkeep, app_tlast, app_tuser};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_beat: unexpected beat %h", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL out_beat: got %h expected %h", got, e);
                    end
                end
            end
            if (payload_tvalid && !payload_tready) bp_cnt++;
            if (pkt_drop) drop_cnt++;
        end
    end

    task automatic send(input logic [15:0] port, input logic [31:0] ip,
                        input byte_q_t bytes, input logic user_last);
        int n;
        @(negedge clk);
        hdr_valid = 1'b1; udp_dest_port = port; ip_source_ip = ip;
        n = 0;
        forever begin
            #1;
            if (hdr_ready) break;
            @(negedge clk);
            if (++n > 100) begin
                total++; bad++;
                $display("FAIL hdr_timeout: hdr_ready stayed 0 expected 1");
                hdr_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        @(negedge clk);
        hdr_valid = 1'b0;
        for (int i = 0; i < bytes.size(); i++) begin
            payload_tvalid = 1'b1;
            payload_tdata  = bytes[i];
            payload_tlast  = (i == bytes.size() - 1);
            payload_tuser  = payload_tlast & user_last;
            n = 0;
            forever begin
                #1;
                if (payload_tready) break;
                @(negedge clk);
                if (++n > 100) begin
                    total++; bad++;
                    $display("FAIL payload_timeout: tready stayed 0 expected 1");
                    payload_tvalid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        payload_tvalid = 1'b0;
        payload_tlast  = 1'b0;
        payload_tuser  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d beats missing expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hdr_ready"}, 64'(hdr_ready), 64'd0);
        check({tag, "_payload_tready"}, 64'(payload_tready), 64'd0);
        check({tag, "_out"}, 64'({app_tvalid, app_tdata, app_tkeep, app_tlast, app_tuser}), 64'd0);
        check({tag, "_transfer_id"}, 64'(transfer_id), 64'd0);
        check({tag, "_pkt_drop"}, 64'(pkt_drop), 64'd0);
    endtask

    initial begin
        byte_q_t q;
        int      d0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("idle_hdr_ready", 64'(hdr_ready), 64'd1);

        // Basic datagram: ID 7 + 8 bytes
        push(32'h0403_0201, 4'hF, 1'b0, 1'b0);
        push(32'h0807_0605, 4'hF, 1'b1, 1'b0);
        send(16'd1234, GOOD_IP, make(32'd7, 8, 8'h01), 1'b0);
        wait_drain();
        check("tid_7", 64'(transfer_id), 64'd7);

        // Partial last word: ID 8 + 5 bytes
        push(32'h1413_1211, 4'hF, 1'b0, 1'b0);
        push(32'h0000_0015, 4'h1, 1'b1, 1'b0);
        send(16'd1234, GOOD_IP, make(32'd8, 5, 8'h11), 1'b0);
        wait_drain();
        check("tid_8", 64'(transfer_id), 64'd8);
        check("no_backpressure", 64'(bp_cnt), 64'd0);

        // Wrong port: dropped, single pulse
        d0 = drop_cnt;
        send(16'd1235, GOOD_IP, make(32'h99, 16, 8'h40), 1'b0);
        wait_drain();
        check("port_drop_pulses", 64'(drop_cnt - d0), 64'd1);
        check("port_drop_tid", 64'(transfer_id), 64'd8);
        #1;
        check("port_drop_hdr_ready", 64'(hdr_ready), 64'd1);

        // Wrong source IP: dropped
        d0 = drop_cnt;
        send(16'd1234, 32'hC0A8_0102, make(32'h55, 3, 8'h60), 1'b0);
        wait_drain();
        check("ip_drop_pulses", 64'(drop_cnt - d0), 64'd1);

        // 3-byte runt
        d0 = drop_cnt;
        q.delete();
        q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00);
        send(16'd1234, GOOD_IP, q, 1'b0);
        wait_drain();
        check("runt3_pulses", 64'(drop_cnt - d0), 64'd1);
        check("runt3_tid", 64'(transfer_id), 64'd8);

        // ID only, no payload: runt
        d0 = drop_cnt;
        send(16'd1234, GOOD_IP, make(32'h0A, 0, 8'h00), 1'b0);
        wait_drain();
        check("runt4_pulses", 64'(drop_cnt - d0), 64'd1);
        check("runt4_tid", 64'(transfer_id), 64'd8);

        // Normal datagram after runts
        push(32'h0000_A2A1, 4'h3, 1'b1, 1'b0);
        send(16'd1234, GOOD_IP, make(32'd9, 2, 8'hA1), 1'b0);
        wait_drain();
        check("tid_9", 64'(transfer_id), 64'd9);

        // Output stall mid-datagram, bad frame on last byte
        bp_cnt = 0;
        push(32'h2423_2221, 4'hF, 1'b0, 1'b0);
        push(32'h2827_2625, 4'hF, 1'b0, 1'b0);
        push(32'h2C2B_2A29, 4'hF, 1'b1, 1'b1);
        fork
            send(16'd1234, GOOD_IP, make(32'd10, 12, 8'h21), 1'b1);
            begin
                repeat (8) @(negedge clk);
                app_tready = 1'b0;
                repeat (10) @(negedge clk);
                app_tready = 1'b1;
            end
        join
        wait_drain();
        check("stall_backpressure", 64'(bp_cnt > 0), 64'd1);
        check("tid_10", 64'(transfer_id), 64'd10);

        // Reset between datagrams, then sequence IDs 5, 6, 9
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_state("rst2");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        push(32'h0403_0201, 4'hF, 1'b1, 1'b0);
        send(16'd1234, GOOD_IP, make(32'd5, 4, 8'h01), 1'b0);
        push(32'h0403_0201, 4'hF, 1'b1, 1'b0);
        send(16'd1234, GOOD_IP, make(32'd6, 4, 8'h01), 1'b0);
        push(32'h0403_0201, 4'hF, 1'b1, SEQ_FLAG);
        send(16'd1234, GOOD_IP, make(32'd9, 4, 8'h01), 1'b0);
        wait_drain();
        check("seq_tid", 64'(transfer_id), 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
